peripheral_mpram_arb_ahb3: RTL and testbench

Shared single-memory AHB3-Lite slave for a tile: `CORES_PER_TILE` AHB-Lite slave ports are round-robin arbitrated onto one `peripheral_mpram_1r1w` instance, one memory access per cycle. Each port is inserted between its core's AHB master and the tile memory. It inserts wait states on `HREADYOUT` while a captured transfer waits for its grant.

---
 rtl/peripheral_ahb3_pkg.sv | 40 ++++
 rtl/peripheral_mpram_arb_ahb3_if.sv | 32 +++
 rtl/peripheral_mpram_1r1w.sv | 28 ++
 rtl/peripheral_mpram_rr_arbiter.sv | 35 +++
 rtl/peripheral_mpram_arb_ahb3.sv | 105 ++++++++++
 tb/tb_peripheral_mpram_arb_ahb3.sv | 304 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// AHB3-Lite encodings and the byte-enable helper shared by the
// tile memory ports.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_128   = 3'b100;
    localparam logic [2:0] HSIZE_256   = 3'b101;
    localparam logic [2:0] HSIZE_512   = 3'b110;
    localparam logic [2:0] HSIZE_1024  = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int BE_MAX = 128;

    // Lanes are aligned to the transfer size and wrap within be_size.
    function automatic logic [BE_MAX-1:0] gen_be(
        input logic [2:0] size,
        input logic [6:0] addr,
        input int         be_size
    );
        logic [BE_MAX-1:0] m;
        int n;
        int off;
        n = 1 << size;
        if (n > be_size) n = be_size;
        m = (BE_MAX'(1) << n) - BE_MAX'(1);
        off = int'(addr) & (be_size - 1) & ~(n - 1);
        return m << off;
    endfunction

endpackage

// File: rtl/peripheral_mpram_arb_ahb3_if.sv
// Per-port AHB3-Lite bundle for the shared tile memory.
interface peripheral_mpram_arb_ahb3_if #(
    parameter int N    = 8,
    parameter int PLEN = 64,
    parameter int XLEN = 64
);
    logic [N-1:0]           HSEL;
    logic [N-1:0][PLEN-1:0] HADDR;
    logic [N-1:0][XLEN-1:0] HWDATA;
    logic [N-1:0][XLEN-1:0] HRDATA;
    logic [N-1:0]           HWRITE;
    logic [N-1:0][2:0]      HSIZE;
    logic [N-1:0][2:0]      HBURST;
    logic [N-1:0][3:0]      HPROT;
    logic [N-1:0][1:0]      HTRANS;
    logic [N-1:0]           HMASTLOCK;
    logic [N-1:0]           HREADY;
    logic [N-1:0]           HREADYOUT;
    logic [N-1:0]           HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST,
        output HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST,
        input  HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/peripheral_mpram_1r1w.sv
// One-read one-write RAM with byte enables and registered read data.
module peripheral_mpram_1r1w #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 64,
    parameter     TECHNOLOGY = "GENERIC"
) (
    input  logic                 clk,
    input  logic [ABITS-1:0]     waddr,
    input  logic                 we,
    input  logic [DBITS/8-1:0]   be,
    input  logic [DBITS-1:0]     din,
    input  logic [ABITS-1:0]     raddr,
    output logic [DBITS-1:0]     dout
);
    logic [DBITS-1:0] mem [2**ABITS];
    logic unused_tech;

    assign unused_tech = (TECHNOLOGY == "GENERIC");

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DBITS / 8; i++) begin
                if (be[i]) mem[waddr][i*8 +: 8] <= din[i*8 +: 8];
            end
        end
        dout <= mem[raddr];
    end
endmodule

// File: rtl/peripheral_mpram_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
module peripheral_mpram_rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [IW-1:0] last;

    always_comb begin
        logic [IW-1:0] j;
        j     = '0;
        gnt   = '0;
        idx   = last;
        valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(last) + i) % N);
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last <= IW'(N - 1);
        else if (valid) last <= idx;
    end
endmodule

// File: rtl/peripheral_mpram_arb_ahb3.sv
// Tile memory shared by several AHB3-Lite ports, one access per cycle,
// round-robin arbitrated; each port stalls until its captured transfer wins.
module peripheral_mpram_arb_ahb3
    import peripheral_ahb3_pkg::*;
#(
    parameter int MEM_SIZE       = 256,
    parameter int MEM_DEPTH      = 256,
    parameter int PLEN           = 64,
    parameter int XLEN           = 64,
    parameter     TECHNOLOGY     = "GENERIC",
    parameter int CORES_PER_TILE = 8
) (
    input logic                       HCLK,
    input logic                       HRESETn,
    peripheral_mpram_arb_ahb3_if.slave bus
);
    localparam int N         = CORES_PER_TILE;
    localparam int BE_SIZE   = XLEN / 8;
    localparam int WORDS     = 8 * MEM_SIZE / XLEN;
    localparam int DEPTH     = (MEM_DEPTH > WORDS) ? MEM_DEPTH : WORDS;
    localparam int MEM_ABITS = $clog2(DEPTH);
    localparam int ABITS_LSB = $clog2(BE_SIZE);
    localparam int IW        = $clog2(N);

    logic [N-1:0]                pend;
    logic [N-1:0]                cap;
    logic [N-1:0]                gnt;
    logic [N-1:0][MEM_ABITS-1:0] cap_addr;
    logic [N-1:0]                cap_wr;
    logic [N-1:0][BE_SIZE-1:0]   cap_be;
    logic [N-1:0][BE_MAX-1:0]    be_full;
    logic [IW-1:0]               gidx;
    logic                        gvalid;
    logic                        we;
    logic [MEM_ABITS-1:0]        waddr;
    logic [MEM_ABITS-1:0]        raddr;
    logic [BE_SIZE-1:0]          be;
    logic [XLEN-1:0]             din;
    logic [XLEN-1:0]             dout;
    logic                        unused_ok;

    always_comb begin
        cap     = '0;
        be_full = '0;
        for (int t = 0; t < N; t++) begin
            cap[t] = bus.HSEL[t] & bus.HREADY[t] &
                     ((bus.HTRANS[t] == HTRANS_NONSEQ) |
                      (bus.HTRANS[t] == HTRANS_SEQ));
            be_full[t] = gen_be(bus.HSIZE[t], bus.HADDR[t][6:0], BE_SIZE);
        end
    end

    always_ff @(posedge HCLK) begin
        for (int t = 0; t < N; t++) begin
            if (cap[t]) begin
                cap_addr[t] <= bus.HADDR[t][ABITS_LSB +: MEM_ABITS];
                cap_wr[t]   <= bus.HWRITE[t];
                cap_be[t]   <= be_full[t][BE_SIZE-1:0];
            end
        end
    end

    // A fresh capture outranks the clear from a grant on the same port.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) pend <= '0;
        else pend <= cap | (pend & ~gnt);
    end

    peripheral_mpram_rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .req   (pend),
        .gnt   (gnt),
        .idx   (gidx),
        .valid (gvalid)
    );

    // The granted port is stalled, so its HWDATA is still on the bus.
    assign we    = gvalid & cap_wr[gidx] & HRESETn;
    assign waddr = cap_addr[gidx];
    assign raddr = cap_addr[gidx];
    assign be    = cap_be[gidx];
    assign din   = bus.HWDATA[gidx];

    peripheral_mpram_1r1w #(
        .ABITS      (MEM_ABITS),
        .DBITS      (XLEN),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_mem (
        .clk   (HCLK),
        .waddr (waddr),
        .we    (we),
        .be    (be),
        .din   (din),
        .raddr (raddr),
        .dout  (dout)
    );

    assign bus.HREADYOUT = ~pend;
    assign bus.HRESP     = {N{HRESP_OKAY}};
    assign bus.HRDATA    = {N{dout}};

    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK,
                         bus.HADDR, be_full};
endmodule

// File: tb/tb_peripheral_mpram_arb_ahb3.sv
// Bench for the shared tile memory: vector table, corner sequences
// and random per-port traffic against a byte-level memory model.
module tb_peripheral_mpram_arb_ahb3;
    import peripheral_ahb3_pkg::*;

    localparam int N     = 4;
    localparam int PLEN  = 64;
    localparam int XLEN  = 64;
    localparam int BYTES = 2048;

    typedef struct {
        bit          wr;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
        int          gap;
        int          lo;
        int          hi;
    } op_t;

    typedef struct {
        int          port;
        bit          wr;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    peripheral_mpram_arb_ahb3_if #(.N(N), .PLEN(PLEN), .XLEN(XLEN)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    peripheral_mpram_arb_ahb3 #(
        .MEM_SIZE       (256),
        .MEM_DEPTH      (256),
        .PLEN           (PLEN),
        .XLEN           (XLEN),
        .TECHNOLOGY     ("GENERIC"),
        .CORES_PER_TILE (N)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    int          total;
    int          bad;
    logic [7:0]  mref [BYTES];
    op_t         ops [N][256];
    int          nops [N];
    int          head [N];
    bit          adrv [N];
    bit          dvalid [N];
    op_t         aop [N];
    op_t         dop [N];
    int          waits [N];
    int          hold [N];
    logic [63:0] lastrd [N];
    vec_t        vt [14];
    logic [63:0] old;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_range(string name, int v, int lo, int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic logic [63:0] ref_word(logic [63:0] a);
        logic [63:0] w;
        int base;
        base = int'(a[10:0]) & ~7;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = mref[base + i];
        return w;
    endfunction

    function automatic void ref_write(op_t o);
        int n;
        int base;
        n = 1 << o.size;
        base = int'(o.addr[10:0]) & ~(n - 1);
        for (int i = 0; i < n; i++)
            mref[base + i] = o.data[((base + i) % 8) * 8 +: 8];
    endfunction

    task automatic add_op(int p, bit wr, logic [2:0] size, logic [63:0] addr,
                          logic [63:0] data, int gap, int lo, int hi);
        ops[p][nops[p]] = '{wr, size, addr, data, gap, lo, hi};
        nops[p]++;
    endtask

    task automatic complete(int p);
        if (dop[p].wr) begin
            ref_write(dop[p]);
        end else begin
            lastrd[p] = bus.HRDATA[p];
            check($sformatf("p%0d read %h", p, dop[p].addr),
                  bus.HRDATA[p], ref_word(dop[p].addr));
        end
        check_range($sformatf("p%0d wait", p), waits[p], dop[p].lo, dop[p].hi);
        check("hresp", 64'(bus.HRESP[p]), 64'h0);
    endtask

    // One bus cycle of every port's master, evaluated just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (adrv[p]) begin
                adrv[p]   = 1'b0;
                dvalid[p] = 1'b1;
                dop[p]    = aop[p];
                waits[p]  = 0;
                bus.HWDATA[p] = aop[p].data;
            end
            if (dvalid[p]) begin
                if (bus.HREADYOUT[p]) begin
                    complete(p);
                    dvalid[p] = 1'b0;
                end else begin
                    waits[p]++;
                end
            end
            bus.HSEL[p]   = 1'b0;
            bus.HTRANS[p] = HTRANS_IDLE;
            if (bus.HREADYOUT[p] && head[p] < nops[p]) begin
                if (hold[p] < ops[p][head[p]].gap) begin
                    hold[p]++;
                    bus.HSEL[p]   = 1'b1;
                    bus.HTRANS[p] = ($urandom_range(1) != 0) ? HTRANS_BUSY : HTRANS_IDLE;
                    bus.HWRITE[p] = 1'b1;
                    bus.HADDR[p]  = ops[p][head[p]].addr;
                    if (!dvalid[p]) bus.HWDATA[p] = {$urandom, $urandom};
                end else begin
                    aop[p]  = ops[p][head[p]];
                    head[p]++;
                    hold[p] = 0;
                    adrv[p] = 1'b1;
                    bus.HSEL[p]   = 1'b1;
                    bus.HTRANS[p] = HTRANS_NONSEQ;
                    bus.HADDR[p]  = aop[p].addr;
                    bus.HWRITE[p] = aop[p].wr;
                    bus.HSIZE[p]  = aop[p].size;
                end
            end
        end
    endtask

    task automatic run(int budget);
        bit busy;
        int c;
        c = 0;
        busy = 1'b1;
        while (busy && c < budget) begin
            step();
            c++;
            busy = 1'b0;
            for (int p = 0; p < N; p++)
                if (head[p] < nops[p] || adrv[p] || dvalid[p]) busy = 1'b1;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL run timeout: got %0d cycles want done", c);
        end
        for (int p = 0; p < N; p++) begin
            nops[p] = 0; head[p] = 0; hold[p] = 0;
            adrv[p] = 1'b0; dvalid[p] = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int p = 0; p < N; p++) begin
            nops[p] = 0; head[p] = 0; hold[p] = 0; waits[p] = 0;
            adrv[p] = 1'b0; dvalid[p] = 1'b0; lastrd[p] = '0;
        end
        bus.HSEL = '0; bus.HADDR = '0; bus.HWDATA = '0; bus.HWRITE = '0;
        bus.HSIZE = '0; bus.HTRANS = '0; bus.HBURST = '0; bus.HPROT = '0;
        bus.HMASTLOCK = '0;

        vt[0]  = '{0, 1'b1, HSIZE_DWORD, 64'h10, 64'hDEADBEEF01234567, 64'h0};
        vt[1]  = '{0, 1'b0, HSIZE_DWORD, 64'h10, 64'h0, 64'hDEADBEEF01234567};
        vt[2]  = '{0, 1'b1, HSIZE_DWORD, 64'h20, 64'h0, 64'h0};
        vt[3]  = '{1, 1'b1, HSIZE_BYTE, 64'h23, 64'h00000000AB000000, 64'h0};
        vt[4]  = '{1, 1'b0, HSIZE_DWORD, 64'h20, 64'h0, 64'h00000000AB000000};
        vt[5]  = '{2, 1'b1, HSIZE_HWORD, 64'h26, 64'h1234000000000000, 64'h0};
        vt[6]  = '{2, 1'b0, HSIZE_DWORD, 64'h20, 64'h0, 64'h12340000AB000000};
        vt[7]  = '{3, 1'b1, HSIZE_WORD, 64'h24, 64'h5566778800000000, 64'h0};
        vt[8]  = '{3, 1'b0, HSIZE_DWORD, 64'h20, 64'h0, 64'h55667788AB000000};
        vt[9]  = '{0, 1'b1, HSIZE_DWORD, 64'h7F8, 64'h0F0E0D0C0B0A0908, 64'h0};
        vt[10] = '{1, 1'b0, HSIZE_DWORD, 64'hFF8, 64'h0, 64'h0F0E0D0C0B0A0908};
        vt[11] = '{2, 1'b0, HSIZE_DWORD, 64'hFFFFFFFF000007F8, 64'h0, 64'h0F0E0D0C0B0A0908};
        vt[12] = '{3, 1'b1, HSIZE_BYTE, 64'h10, 64'h00000000000000FF, 64'h0};
        vt[13] = '{3, 1'b0, HSIZE_DWORD, 64'h10, 64'h0, 64'hDEADBEEF012345FF};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset hreadyout", 64'(bus.HREADYOUT), 64'hF);
        check("reset hresp", 64'(bus.HRESP), 64'h0);

        for (int w = 0; w < 256; w++)
            add_op(w % N, 1'b1, HSIZE_DWORD, 64'(w * 8), {$urandom, $urandom}, 0, 1, N);
        run(2000);

        for (int i = 0; i < 14; i++) begin
            add_op(vt[i].port, vt[i].wr, vt[i].size, vt[i].addr, vt[i].data, 0, 1, 1);
            run(50);
            if (!vt[i].wr) check($sformatf("vec%0d", i), lastrd[vt[i].port], vt[i].exp);
        end

        // all ports collide right after reset: port 0 first, port 3 last
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int p = 0; p < N; p++)
            add_op(p, 1'b0, HSIZE_DWORD, 64'(p * 8 + 'h300), 64'h0, 0, p + 1, p + 1);
        run(50);

        for (int k = 0; k < 10; k++) begin
            add_op(0, 1'b1, HSIZE_DWORD, 64'(k * 8 + 'h100), {$urandom, $urandom}, 0, 1, 2);
            add_op(2, 1'b1, HSIZE_DWORD, 64'(k * 8 + 'h180), {$urandom, $urandom}, 0, 1, 2);
        end
        for (int k = 0; k < 10; k++) begin
            add_op(0, 1'b0, HSIZE_DWORD, 64'(k * 8 + 'h100), 64'h0, 0, 1, 2);
            add_op(2, 1'b0, HSIZE_DWORD, 64'(k * 8 + 'h180), 64'h0, 0, 1, 2);
        end
        run(500);

        // a pending write is dropped by reset
        old = ref_word(64'h40);
        @(posedge clk);
        #1;
        bus.HSEL[1] = 1'b1; bus.HTRANS[1] = HTRANS_NONSEQ; bus.HADDR[1] = 64'h40;
        bus.HWRITE[1] = 1'b1; bus.HSIZE[1] = HSIZE_DWORD;
        @(posedge clk);
        #1;
        check("mid pending", 64'(bus.HREADYOUT[1]), 64'h0);
        bus.HSEL[1] = 1'b0; bus.HTRANS[1] = HTRANS_IDLE;
        bus.HWDATA[1] = ~old; rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid ready", 64'(bus.HREADYOUT), 64'hF);
        add_op(1, 1'b0, HSIZE_DWORD, 64'h40, 64'h0, 0, 1, 1);
        run(50);
        check("mid old", lastrd[1], old);

        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("idle ready", 64'(bus.HREADYOUT), 64'hF);
            bus.HSEL = '1;
            for (int p = 0; p < N; p++) begin
                bus.HTRANS[p] = ((c + p) % 2 != 0) ? HTRANS_BUSY : HTRANS_IDLE;
                bus.HWRITE[p] = 1'b1;
                bus.HSIZE[p]  = HSIZE_DWORD;
                bus.HADDR[p]  = 64'h48;
                bus.HWDATA[p] = {$urandom, $urandom};
            end
        end
        @(posedge clk);
        #1;
        check("idle ready end", 64'(bus.HREADYOUT), 64'hF);
        bus.HSEL = '0;
        bus.HTRANS = '0;
        for (int p = 0; p < N; p++) add_op(p, 1'b0, HSIZE_DWORD, 64'h48, 64'h0, 0, 1, N);
        run(50);

        // random traffic, each port confined to its own 64-word slice
        for (int p = 0; p < N; p++) begin
            for (int k = 0; k < 40; k++) begin
                logic [2:0]  sz;
                logic [63:0] a;
                int          n;
                int          gap;
                sz = 3'($urandom_range(3));
                n  = 1 << sz;
                a  = {$urandom, $urandom};
                a[10:0] = 11'((p * 64 + int'($urandom_range(63))) * 8 +
                              (int'($urandom_range(7)) & ~(n - 1)));
                gap = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
                add_op(p, 1'($urandom_range(1)), sz, a, {$urandom, $urandom}, gap, 1, N);
            end
        end
        run(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
